// File: rtl/store_pkg.sv
// Shared types and helpers for the store path (store_unit, store_fifo).
// STORE_SPLIT_EN (optional) enables boundary-crossing stores in store_unit.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    // Fields are sized for the widest legal configuration; narrower builds use the low bits.
    localparam int unsigned ENTRY_ADDR_W = 64;
    localparam int unsigned ENTRY_DATA_W = 64;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        size_e                   size;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

    function automatic logic [7:0] lane_mask(input size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] align_mask(input size_e sz);
        logic [2:0] m;
        case (sz)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered storage and occupancy count.
module store_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store path: legality check, store buffer, byte-lane alignment and drain FSM to memory.
// Optional macro STORE_SPLIT_EN: misaligned stores allowed; boundary-crossing stores take two beats.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [XLEN-1:0]           st_data,
    input  logic [1:0]                st_size,
    output logic                      st_err,
    output logic                      mem_req,
    input  logic                      mem_gnt,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [XLEN-1:0]           mem_wdata,
    output logic [XLEN/8-1:0]         mem_be,
    output logic [$clog2(DEPTH):0]    sb_count,
    output logic                      sb_empty
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e               r_state;
    state_e               w_next;
    logic                 r_st_err;

    size_e                w_req_size;
    logic                 w_size_bad;
    logic                 w_misalign;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    entry_t               w_push_entry;

    logic [$bits(entry_t)-1:0] w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    entry_t               w_head;

    logic [OFF_W-1:0]     w_off;
    logic [4:0]           w_bytes;
    logic [4:0]           w_span;
    logic                 w_cross;
    logic                 w_more;
    logic [7:0]           w_mask8;
    logic [NB-1:0]        w_mask;
    logic [2*NB-1:0]      w_be_wide;
    logic [XLEN-1:0]      w_data_m;
    logic [2*XLEN-1:0]    w_data_wide;
    logic [ADDR_W-1:0]    w_base;
    logic                 w_unused;

    assign st_ready = (sb_count != CNT_W'(DEPTH));
    assign st_err   = r_st_err;
    assign sb_empty = (sb_count == '0) && (r_state == IDLE);

    always_comb begin
        w_req_size = size_e'(st_size);
        w_size_bad = (w_req_size == SZ_D) && (XLEN == 32);
`ifdef STORE_SPLIT_EN
        w_misalign = 1'b0;
`else
        w_misalign = |(st_addr[2:0] & align_mask(w_req_size));
`endif
        w_illegal  = w_size_bad || w_misalign;
        w_accept   = st_valid && st_ready;
        w_push     = w_accept && !w_illegal;

        w_push_entry                   = '0;
        w_push_entry.addr[ADDR_W-1:0]  = st_addr;
        w_push_entry.size              = w_req_size;
        w_push_entry.data[XLEN-1:0]    = st_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_err <= 1'b0;
        end else begin
            r_st_err <= w_accept && w_illegal;
        end
    end

    store_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (sb_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Both beats come from one double-width shift: low half is beat 0, high half beat 1.
    always_comb begin
        w_head    = entry_t'(w_fifo_dout);
        w_off     = w_head.addr[OFF_W-1:0];
        w_bytes   = 5'd1 << w_head.size;
        w_span    = 5'(w_off) + w_bytes;
        w_cross   = (w_span > 5'(NB));
        w_mask8   = lane_mask(w_head.size);
        w_mask    = w_mask8[NB-1:0];

        w_be_wide          = '0;
        w_be_wide[NB-1:0]  = w_mask;
        w_be_wide          = w_be_wide << w_off;

        for (int unsigned i = 0; i < NB; i++) begin
            w_data_m[8*i +: 8] = w_mask[i] ? w_head.data[8*i +: 8] : 8'h00;
        end
        w_data_wide             = '0;
        w_data_wide[XLEN-1:0]   = w_data_m;
        w_data_wide             = w_data_wide << {w_off, 3'b000};

        w_base = {w_head.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // A push in the popping cycle refills the buffer, so stay in BEAT0 rather than idling.
    assign w_more = (sb_count > CNT_W'(1)) || w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_next = BEAT0;
                end
            end
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = w_base;
                mem_wdata = w_data_wide[XLEN-1:0];
                mem_be    = w_be_wide[NB-1:0];
                if (mem_gnt) begin
`ifdef STORE_SPLIT_EN
                    if (w_cross) begin
                        w_next = BEAT1;
                    end else begin
                        w_pop  = 1'b1;
                        w_next = w_more ? BEAT0 : IDLE;
                    end
`else
                    w_pop  = 1'b1;
                    w_next = w_more ? BEAT0 : IDLE;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = w_base + ADDR_W'(NB);
                mem_wdata = w_data_wide[2*XLEN-1:XLEN];
                mem_be    = w_be_wide[2*NB-1:NB];
                if (mem_gnt) begin
                    w_pop  = 1'b1;
                    w_next = w_more ? BEAT0 : IDLE;
                end
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_unused = ^{w_head, w_cross, w_be_wide, w_data_wide, w_fifo_full};

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit (XLEN=32, DEPTH=4); covers both STORE_SPLIT_EN builds.
module tb_store_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [XLEN-1:0]   st_data;
    logic [1:0]        st_size;
    logic              st_err;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [3:0]        mem_be;
    logic [2:0]        sb_count;
    logic              sb_empty;

    int n_checks = 0;
    int n_errors = 0;

    store_unit #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .sb_count  (sb_count),
        .sb_empty  (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d);
        check({tag, "_req"},   64'(mem_req),   64'd1);
        check({tag, "_addr"},  64'(mem_addr),  64'(a));
        check({tag, "_be"},    64'(mem_be),    64'(be));
        check({tag, "_wdata"}, 64'(mem_wdata), 64'(d));
    endtask

    // Waits (bounded) for mem_req at a falling edge, then checks the beat.
    task automatic expect_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        check_beat(tag, a, be, d);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"}, 64'(st_err), 64'd1);
        @(negedge clk);
        check({tag, "_err_clr"}, 64'(st_err),   64'd0);
        check({tag, "_noreq"},   64'(mem_req),  64'd0);
        check({tag, "_count"},   64'(sb_count), 64'd0);
    endtask

    logic [31:0] bp_addr  [4] = '{32'h3000, 32'h3002, 32'h3004, 32'h3009};
    logic [31:0] bp_data  [4] = '{32'hFFFF_FF11, 32'h0000_2233, 32'h4455_6677, 32'h0000_0088};
    logic [1:0]  bp_size  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] bp_maddr [4] = '{32'h3000, 32'h3000, 32'h3004, 32'h3008};
    logic [3:0]  bp_be    [4] = '{4'b0001, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] bp_wdata [4] = '{32'h0000_0011, 32'h2233_0000, 32'h4455_6677, 32'h0000_8800};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        mem_gnt  = 1'b1;

        #12;
        check("rst_req",   64'(mem_req),   64'd0);
        check("rst_addr",  64'(mem_addr),  64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_be",    64'(mem_be),    64'd0);
        check("rst_err",   64'(st_err),    64'd0);
        check("rst_count", 64'(sb_count),  64'd0);
        check("rst_empty", 64'(sb_empty),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(st_ready), 64'd1);

        push(32'h1003, 32'h0000_00AB, 2'b00);
        check("sb_latency_noreq", 64'(mem_req), 64'd0);
        expect_beat("sb", 32'h1000, 4'b1000, 32'hAB00_0000);

        push(32'h1001, 32'hFFFF_FF5A, 2'b00);
        expect_beat("sb_trunc", 32'h1000, 4'b0010, 32'h0000_5A00);

        push(32'h1002, 32'h0000_1234, 2'b01);
        expect_beat("sh", 32'h1000, 4'b1100, 32'h1234_0000);

        push(32'h2000, 32'hCAFE_F00D, 2'b10);
        expect_beat("sw", 32'h2000, 4'b1111, 32'hCAFE_F00D);

`ifdef STORE_SPLIT_EN
        push(32'h1006, 32'hDEAD_BEEF, 2'b10);
        expect_beat("split_b0", 32'h1004, 4'b1100, 32'hBEEF_0000);
        expect_beat("split_b1", 32'h1008, 4'b0011, 32'h0000_DEAD);

        push(32'h1001, 32'h0000_1234, 2'b01);
        expect_beat("mis_sh", 32'h1000, 4'b0110, 32'h0012_3400);
`else
        push(32'h1006, 32'hDEAD_BEEF, 2'b10);
        expect_err("mis_sw");

        push(32'h1001, 32'h0000_1234, 2'b01);
        expect_err("mis_sh");
`endif

        push(32'h1000, 32'h0123_4567, 2'b11);
        expect_err("size11");

        // push and pop in the same cycle
        mem_gnt = 1'b0;
        push(32'h4000, 32'h0000_0001, 2'b00);
        @(negedge clk);
        mem_gnt  = 1'b1;
        st_valid = 1'b1;
        st_addr  = 32'h4004;
        st_data  = 32'h0000_0002;
        st_size  = 2'b00;
        @(negedge clk);
        st_valid = 1'b0;
        check("pushpop_count", 64'(sb_count), 64'd1);
        check_beat("pushpop_next", 32'h4004, 4'b0001, 32'h0000_0002);
        @(negedge clk);
        check("pushpop_drained", 64'(sb_count), 64'd0);

        // back-pressure: fill the buffer with the memory stalled
        mem_gnt = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = bp_addr[i];
            st_data  = bp_data[i];
            st_size  = bp_size[i];
            @(negedge clk);
        end
        st_valid = 1'b0;
        check("bp_count", 64'(sb_count), 64'd4);
        check("bp_ready", 64'(st_ready), 64'd0);
        st_valid = 1'b1;
        st_addr  = 32'h7000;
        st_data  = 32'h0000_0099;
        st_size  = 2'b00;
        @(negedge clk);
        st_valid = 1'b0;
        check("bp_full_count", 64'(sb_count), 64'd4);
        for (int c = 0; c < 5; c++) begin
            check_beat("bp_hold", bp_maddr[0], bp_be[0], bp_wdata[0]);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check_beat("bp_drain", bp_maddr[k], bp_be[k], bp_wdata[k]);
        end
        @(negedge clk);
        check("bp_done_req",   64'(mem_req),  64'd0);
        check("bp_done_empty", 64'(sb_empty), 64'd1);
        check("bp_done_count", 64'(sb_count), 64'd0);

        // reset while a beat is outstanding
        mem_gnt = 1'b0;
`ifdef STORE_SPLIT_EN
        push(32'h1006, 32'hDEAD_BEEF, 2'b10);
        expect_beat("rmid_b0", 32'h1004, 4'b1100, 32'hBEEF_0000);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_beat("rmid_b1", 32'h1008, 4'b0011, 32'h0000_DEAD);
`else
        push(32'h5000, 32'h1111_1111, 2'b10);
        push(32'h5004, 32'h2222_2222, 2'b10);
        expect_beat("rmid_b0", 32'h5000, 4'b1111, 32'h1111_1111);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_req",   64'(mem_req),  64'd0);
        check("rmid_count", 64'(sb_count), 64'd0);
        check("rmid_be",    64'(mem_be),   64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        seen    = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        check("rmid_no_stale", 64'(seen),     64'd0);
        check("rmid_empty",    64'(sb_empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Parametrised store path between the execute stage and data memory. Accepts store requests (address, data, size), buffers them in a small FIFO, and drains them to memory. Each drained store is placed into the correct byte lanes with a matching byte-enable mask. Replaces the earlier purely combinational store-data select, which only truncated or extended the data. This block aligns data to the address, generates byte enables, supports XLEN 32/64, and handles memory back-pressure.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 byte lanes
- ADDR_W, 32, address width
- DEPTH, 4, store-buffer entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept a request
- st_addr  in  ADDR_W  byte address
- st_data  in  XLEN  store data, right-justified
- st_size  in  2  size: 00 byte, 01 half, 10 word, 11 double (double legal only when XLEN=64)
- st_err  out  1  one-cycle pulse: the request was rejected
- mem_req  out  1  memory write request
- mem_gnt  in  1  memory accepts the current beat
- mem_addr  out  ADDR_W  NB-aligned beat address
- mem_wdata  out  XLEN  lane-aligned write data
- mem_be  out  NB  byte enables
- sb_count  out  $clog2(DEPTH)+1  number of occupied entries
- sb_empty  out  1  buffer empty and no beat in flight

## Operation
- Request acceptance:
  - A request is accepted on st_valid && st_ready; st_ready = (sb_count != DEPTH).
  - There is no push-while-full bypass, even if a pop occurs in the same cycle.
- Illegal requests:
  - These are: size 11 with XLEN=32, and misaligned requests per Configuration.
  - An illegal request is still handshaked (consumed) but is not enqueued. st_err pulses the next cycle.
- Lane computation for each drained entry:
  - off = addr mod NB; bytes = 1 << size; mask = (1 << bytes) - 1.
  - Beat 0: mem_addr = addr with its low log2(NB) bits cleared; mem_wdata = data << 8*off; mem_be = (mask << off) truncated to NB bits.
  - Beat 1 (split stores only): mem_addr = beat-0 address + NB; mem_wdata = data >> 8*(NB-off); mem_be = mask >> (NB-off).
  - Unused lanes of mem_wdata are driven 0.
- Drain FSM:
  - IDLE: buffer empty, mem_req=0. Go to BEAT0 when the buffer is non-empty.
  - BEAT0: mem_req=1. On mem_gnt: if off+bytes > NB, go to BEAT1; otherwise pop the entry and go to BEAT0 if more entries remain, else IDLE.
  - BEAT1: mem_req=1. On mem_gnt: pop the entry, then go to BEAT0 or IDLE.
- Stores drain strictly in acceptance order. No merging.

## Timing
- Reset values: mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; st_err=0; sb_count=0; sb_empty=1; FSM=IDLE. st_ready=1 once reset is released.
- Latency: a store accepted in cycle N drives mem_req no earlier than N+1, because the FIFO is registered.
- While mem_req && !mem_gnt, mem_addr, mem_wdata and mem_be are held stable.
- Back-to-back throughput with mem_gnt tied high:
  - One beat per cycle.
  - A split store occupies two consecutive cycles.
- Simultaneous push and pop: sb_count is unchanged.
- Reset asserted mid-drain (including in BEAT1): all entries are discarded and mem_req falls immediately (asynchronously).

## Configuration
- STORE_SPLIT_EN defined:
  - Any alignment is legal.
  - A store with off+bytes > NB is issued as two beats.
  - A store that is misaligned but does not cross a boundary is issued as one beat.
- STORE_SPLIT_EN undefined:
  - Any request with addr mod bytes != 0 is illegal and raises st_err.
  - BEAT1 does not exist; the FSM has only IDLE and BEAT0.

## Structure
- Package store_pkg holds:
  - size enum: SZ_B, SZ_H, SZ_W, SZ_D
  - FSM state enum: IDLE, BEAT0, BEAT1
  - entry struct: addr, size, data
  - lane-mask function
- Sub-module store_fifo: a generic DEPTH-entry synchronous FIFO with push/pop/count. It is instantiated once.
- The top level holds the legality check, lane computation and drain FSM.

## Test plan
All cases use XLEN=32 unless noted.
- Byte store: sb addr 0x1003, data 0x000000AB -> one beat: mem_addr 0x1000, mem_be 1000, mem_wdata 0xAB000000.
- Halfword store: sh addr 0x1002, data 0x00001234 -> mem_be 1100, mem_wdata 0x12340000.
- Split on: sw addr 0x1006, data 0xDEADBEEF, STORE_SPLIT_EN defined -> two beats:
  - Beat 0: 0x1004, be 1100, wdata 0xBEEF0000.
  - Beat 1: 0x1008, be 0011, wdata 0x0000DEAD.
- Split off: the same sw with STORE_SPLIT_EN undefined -> st_err pulses one cycle; no mem_req; sb_count stays 0. Size 11 -> st_err.
- Back-pressure: mem_gnt=0, 4 stores pushed (DEPTH=4) -> st_ready=0 and sb_count=4; mem outputs stable for 5 cycles. Then mem_gnt=1 -> 4 beats in order, ending with sb_empty=1.
- Reset mid-op: rst_n low during BEAT1 -> mem_req=0 the same cycle, sb_count=0; after release, no stale beat is issued.
